scan_test_ctrl: RTL and testbench

SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

---
 rtl/scan_pkg.sv | 14 +
 rtl/scan_test_ctrl.sv | 123 ++++++++++++
 tb/tb_scan_test_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan test controller.
package scan_pkg;

  localparam int unsigned ChainLenDefault = 3;

  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StCapture,
    StShiftOut,
    StDone
  } scan_state_t;

endpackage

// File: rtl/scan_test_ctrl.sv
// Scan test controller: load a vector serially, pulse one capture cycle, unload and
// compare the result against an expected vector under a care mask.
module scan_test_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = ChainLenDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] load_vec,
  input  logic [CHAIN_LEN-1:0] expect_vec,
  input  logic [CHAIN_LEN-1:0] care_mask,
  input  logic                 scan_out,
  output logic                 scan_mode,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] unload_vec
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CHAIN_LEN - 1);

  scan_state_t          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] load_q, expect_q, mask_q;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic [CHAIN_LEN-1:0] unload_q, unload_d;
  logic                 pass_q, pass_d;
  logic                 latch_en;
  logic [CHAIN_LEN-1:0] onehot;
  logic [CHAIN_LEN-1:0] cap_bit;

  // Next-state, counter, capture buffer and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    cap_d      = cap_q;
    unload_d   = unload_q;
    pass_d     = pass_q;
    latch_en   = 1'b0;
    scan_mode  = 1'b0;
    scan_in    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    pass       = pass_q;
    unload_vec = unload_q;
    // Bit position addressed by the current shift cycle.
    onehot     = CHAIN_LEN'(1) << cnt_q;
    cap_bit    = scan_out ? (cap_q | onehot) : (cap_q & ~onehot);

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          latch_en = 1'b1;
          cap_d    = '0;
          state_d  = StShiftIn;
        end
      end
      StShiftIn: begin
        scan_mode = 1'b1;
        scan_in   = |(load_q & onehot);
        if (cnt_q == CntLast) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapture: begin
        state_d = StShiftOut;
      end
      StShiftOut: begin
        scan_mode = 1'b1;
        cap_d     = cap_bit;
        if (cnt_q == CntLast) begin
          // Publish result and verdict together so both are valid during DONE.
          unload_d = cap_bit;
          pass_d   = &(~(cap_bit ^ expect_q) | ~mask_q);
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State, counter and vector registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      load_q   <= '0;
      expect_q <= '0;
      mask_q   <= '0;
      cap_q    <= '0;
      unload_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      unload_q <= unload_d;
      pass_q   <= pass_d;
      if (latch_en) begin
        load_q   <= load_vec;
        expect_q <= expect_vec;
        mask_q   <= care_mask;
      end
    end
  end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: 3-flop chain model plus a timeline model of the run, and a
// second instance with a single-flop chain.
module tb_scan_test_ctrl;

  localparam int L = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] load_vec = '0, expect_vec = '0, care_mask = '0;
  logic       scan_out, scan_mode, scan_in, busy, done, pass;
  logic [2:0] unload_vec;

  logic       start1 = 1'b0;
  logic [0:0] l1 = '0, e1 = '0, m1 = '0;
  logic       so1, sm1, si1, b1, d1, p1;
  logic [0:0] u1;

  int total = 0;
  int bad = 0;
  int ndone = 0;
  bit checking = 1'b0;

  scan_test_ctrl #(.CHAIN_LEN(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .load_vec  (load_vec),
    .expect_vec(expect_vec),
    .care_mask (care_mask),
    .scan_out  (scan_out),
    .scan_mode (scan_mode),
    .scan_in   (scan_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .unload_vec(unload_vec)
  );

  scan_test_ctrl #(.CHAIN_LEN(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .start     (start1),
    .load_vec  (l1),
    .expect_vec(e1),
    .care_mask (m1),
    .scan_out  (so1),
    .scan_mode (sm1),
    .scan_in   (si1),
    .busy      (b1),
    .done      (d1),
    .pass      (p1),
    .unload_vec(u1)
  );

  // Non-inverting chains that hold when scan_mode is low.
  logic [2:0] chain = '0;
  logic       chain1 = 1'b0;
  always @(posedge clk) begin
    if (scan_mode) chain <= {chain[1:0], scan_in};
    if (sm1) chain1 <= si1;
  end
  assign scan_out = chain[2];
  assign so1 = chain1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Run timeline: t = cycles since start was sampled (0 = idle).
  int         t = 0;
  logic [2:0] ld_m = '0, ex_m = '0, mk_m = '0, u_m = '0;
  logic       p_m = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      t = 0; u_m = '0; p_m = 1'b0;
    end else if (t == 0) begin
      if (start) begin
        t = 1; ld_m = load_vec; ex_m = expect_vec; mk_m = care_mask;
      end
    end else if (t == 2 * L + 2) begin
      t = 0;
    end else begin
      t++;
      if (t == 2 * L + 2) begin
        u_m = ld_m;
        p_m = &(~(ld_m ^ ex_m) | ~mk_m);
      end
    end
  end

  // Every-cycle comparison against the timeline model.
  always @(negedge clk) begin
    if (checking) begin
      logic e_mode, e_in;
      e_mode = (t >= 1 && t <= L) || (t >= L + 2 && t <= 2 * L + 1);
      e_in = (t >= 1 && t <= L) ? ld_m[t-1] : 1'b0;
      check("scan_mode", 32'(scan_mode), 32'(e_mode));
      check("scan_in", 32'(scan_in), 32'(e_in));
      check("busy", 32'(busy), 32'(t != 0));
      check("done", 32'(done), 32'(t == 2 * L + 2));
      check("pass", 32'(pass), 32'(p_m));
      check("unload_vec", 32'(unload_vec), 32'(u_m));
      if (done === 1'b1) ndone++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run3(input logic [2:0] ld, input logic [2:0] ex, input logic [2:0] mk,
                      input logic [2:0] want_u, input logic want_p, input string tag);
    int n;
    logic [2:0] seq;
    logic cap_mode;
    seq = '0;
    cap_mode = 1'b1;
    load_vec = ld; expect_vec = ex; care_mask = mk; start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      if (n <= 3) seq[n-1] = scan_in;
      if (n == 4) cap_mode = scan_mode;
      tick;
      n++;
    end
    check({tag, " latency"}, n, 8);
    check({tag, " scan_in seq"}, 32'(seq), 32'(ld));
    check({tag, " capture mode"}, 32'(cap_mode), 0);
    check({tag, " unload"}, 32'(unload_vec), 32'(want_u));
    check({tag, " pass"}, 32'(pass), 32'(want_p));
    tick;
    check({tag, " busy after"}, 32'(busy), 0);
  endtask

  initial begin
    int n;
    int d0;
    tick;
    tick;
    check("reset scan_mode", 32'(scan_mode), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset pass", 32'(pass), 0);
    check("reset unload", 32'(unload_vec), 0);
    reset = 1'b0;
    checking = 1'b1;
    tick;

    run3(3'b101, 3'b101, 3'b111, 3'b101, 1'b1, "match");
    run3(3'b101, 3'b100, 3'b111, 3'b101, 1'b0, "mismatch");
    run3(3'b101, 3'b100, 3'b110, 3'b101, 1'b1, "mask");
    run3(3'b011, 3'b000, 3'b000, 3'b011, 1'b1, "nomask");

    // Restart attempts during SHIFT_OUT and during DONE are dropped.
    load_vec = 3'b101; expect_vec = 3'b101; care_mask = 3'b111; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    start = 1'b1; load_vec = 3'b010;
    tick;
    start = 1'b0;
    d0 = ndone;
    n = 6;
    while (done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    check("restart latency", n, 8);
    check("restart unload", 32'(unload_vec), 32'(3'b101));
    start = 1'b1;
    tick;
    start = 1'b0;
    check("restart busy after", 32'(busy), 0);
    repeat (20) tick;
    check("restart done count", ndone - d0, 1);

    // Reset in the second SHIFT_IN cycle, with start coincident.
    load_vec = 3'b110; expect_vec = 3'b110; care_mask = 3'b111; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    reset = 1'b1; start = 1'b1;
    tick;
    reset = 1'b0; start = 1'b0;
    check("abort scan_mode", 32'(scan_mode), 0);
    check("abort busy", 32'(busy), 0);
    check("abort unload", 32'(unload_vec), 0);
    d0 = ndone;
    repeat (20) tick;
    check("abort no done", ndone - d0, 0);
    run3(3'b011, 3'b011, 3'b111, 3'b011, 1'b1, "after abort");

    // Single-flop chain.
    l1 = 1'b1; e1 = 1'b1; m1 = 1'b1; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    n = 1;
    while (d1 !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check("len1 latency", n, 4);
    check("len1 pass", 32'(p1), 1);
    check("len1 unload", 32'(u1), 1);
    tick;
    check("len1 busy after", 32'(b1), 0);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
